// File: rtl/adder_arbiter.sv
// adder_arbiter
// Round-robin arbiter that time-shares one combinational adder between NREQ
// requesters and returns each result over a valid/ready channel tagged with
// the owner's index.
//
// Ports
//   clk        sole clock, all state on posedge
//   reset      synchronous, active-high; discards any in-flight operation
//   req        per-requester request level
//   req_a/b    packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot grant pulse, one cycle long
//   add_a/b    registered operands to the shared adder
//   add_sum    combinational sum from the shared adder
//   rsp_*      registered response (valid/ready, owner id, sum)
//   busy       high whenever the FSM is not idle
//   op_count   completed-operation counter, wraps at 255
//
// state | meaning
// IDLE  | waiting for any request; grants on the edge it sees one
// EXEC  | operands on the adder; sum captured on the next edge
// RESP  | response held until rsp_ready
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_sum,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  busy,
  output logic [7:0]            op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDW-1:0]     ptr, ptr_nxt;
  logic [IDW-1:0]     cur_id, cur_id_nxt;
  logic [NREQ-1:0]    gnt_nxt;
  logic [WIDTH-1:0]   add_a_nxt, add_b_nxt;
  logic               rsp_valid_nxt;
  logic [IDW-1:0]     rsp_id_nxt;
  logic [WIDTH-1:0]   rsp_sum_nxt;
  logic [7:0]         op_count_nxt;

  // Round-robin pick: first set bit of req starting at ptr, wrapping.
  logic found;
  int   sel;

  always_comb begin
    int idx;
    found = 1'b0;
    sel   = 0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      gnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      op_count  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cur_id    <= cur_id_nxt;
      gnt       <= gnt_nxt;
      add_a     <= add_a_nxt;
      add_b     <= add_b_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
      rsp_sum   <= rsp_sum_nxt;
      op_count  <= op_count_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cur_id_nxt    = cur_id;
    gnt_nxt       = '0;
    add_a_nxt     = add_a;
    add_b_nxt     = add_b;
    rsp_valid_nxt = rsp_valid;
    rsp_id_nxt    = rsp_id;
    rsp_sum_nxt   = rsp_sum;
    op_count_nxt  = op_count;

    case (state)
      IDLE: begin
        if (found) begin
          // Constant-index mux keeps the part-selects static.
          for (int k = 0; k < NREQ; k++) begin
            if (k == sel) begin
              gnt_nxt[k] = 1'b1;
              add_a_nxt  = req_a[k*WIDTH +: WIDTH];
              add_b_nxt  = req_b[k*WIDTH +: WIDTH];
            end
          end
          cur_id_nxt = IDW'(sel);
          ptr_nxt    = (sel == NREQ - 1) ? '0 : IDW'(sel + 1);
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_nxt   = add_sum;
        rsp_id_nxt    = cur_id;
        rsp_valid_nxt = 1'b1;
        state_nxt     = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          op_count_nxt  = op_count + 8'd1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: a table of single-requester operations
// followed by hand-written round-robin, backpressure, reset and withdraw
// sequences. Inputs change and outputs are checked 1 time unit after posedge.
module tb_adder_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      add_a, add_b, add_sum;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  busy;
  logic [7:0]            op_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  assign add_sum = add_a + add_b;

  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .busy(busy), .op_count(op_count)
  );

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0,   8'd2, 8'd120, 8'd122};
    vecs[1] = '{2, 8'd200, 8'd100,  8'd44};
    vecs[2] = '{1, 8'd255,   8'd1,   8'd0};
    vecs[3] = '{3, 8'd100,  8'd27, 8'd127};
    vecs[4] = '{3, 8'd128, 8'd128,   8'd0};
    vecs[5] = '{0,   8'd0,   8'd0,   8'd0};

    reset = 1'b1; req = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    step(); step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_add_a", 32'(add_a), 0);
    chk("rst_add_b", 32'(add_b), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_sum", 32'(rsp_sum), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(op_count), 0);
    reset = 1'b0;
    step();
    chk("idle_gnt", 32'(gnt), 0);

    // Table: one requester per operation, operands altered after grant.
    rsp_ready = 1'b1;
    foreach (vecs[v]) begin
      req = '0;
      req[vecs[v].idx] = 1'b1;
      set_ops(vecs[v].idx, vecs[v].a, vecs[v].b);
      step();
      req = '0;
      set_ops(vecs[v].idx, 8'h5a, 8'h33);
      chk("v_gnt", 32'(gnt), 32'(1) << vecs[v].idx);
      chk("v_add_a", 32'(add_a), 32'(vecs[v].a));
      chk("v_add_b", 32'(add_b), 32'(vecs[v].b));
      chk("v_busy", 32'(busy), 1);
      step();
      chk("v_gnt_off", 32'(gnt), 0);
      chk("v_valid", 32'(rsp_valid), 1);
      chk("v_id", 32'(rsp_id), 32'(vecs[v].idx));
      chk("v_sum", 32'(rsp_sum), 32'(vecs[v].sum));
      step();
      exp_cnt++;
      chk("v_valid_off", 32'(rsp_valid), 0);
      chk("v_cnt", 32'(op_count), 32'(exp_cnt));
      chk("v_idle", 32'(busy), 0);
    end

    // Round-robin from ptr=0 with all four requesting.
    reset = 1'b1; step(); reset = 1'b0;
    exp_cnt = 0;
    chk("rr_cnt0", 32'(op_count), 0);
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i), 8'(10*i));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int e;
      e = n % NREQ;
      step();
      if (n == 4) req = '0;
      chk("rr_gnt", 32'(gnt), 32'(1) << e);
      chk("rr_add_a", 32'(add_a), 32'(e));
      step();
      chk("rr_gnt_off", 32'(gnt), 0);
      chk("rr_id", 32'(rsp_id), 32'(e));
      chk("rr_sum", 32'(rsp_sum), 32'(11*e));
      step();
      exp_cnt++;
      chk("rr_cnt", 32'(op_count), 32'(exp_cnt));
      if (n == 3) chk("rr_cnt4", 32'(op_count), 4);
    end

    // Backpressure: ptr=1, requester 3 granted, then requester 1 waits.
    set_ops(3, 8'd50, 8'd60);
    set_ops(1, 8'd5, 8'd6);
    req = 4'b1000;
    step();
    chk("bp_gnt3", 32'(gnt), 32'b1000);
    req = 4'b0010;
    rsp_ready = 1'b0;
    set_ops(3, 8'hff, 8'hff);
    step();
    chk("bp_valid", 32'(rsp_valid), 1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_id", 32'(rsp_id), 3);
      chk("bp_hold_sum", 32'(rsp_sum), 110);
      chk("bp_no_gnt", 32'(gnt), 0);
    end
    rsp_ready = 1'b1;
    step();
    exp_cnt++;
    chk("bp_release", 32'(rsp_valid), 0);
    chk("bp_cnt", 32'(op_count), 32'(exp_cnt));
    chk("bp_idle", 32'(busy), 0);
    step();
    req = '0;
    chk("bp_gnt1", 32'(gnt), 32'b0010);
    step();
    chk("bp_id1", 32'(rsp_id), 1);
    chk("bp_sum1", 32'(rsp_sum), 11);
    step();
    exp_cnt++;
    chk("bp_cnt2", 32'(op_count), 32'(exp_cnt));

    // Reset during EXEC discards the op and clears ptr.
    set_ops(0, 8'd9, 8'd9);
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b0001;
    step();
    chk("rm_gnt", 32'(gnt), 1);
    req = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rm_gnt0", 32'(gnt), 0);
    chk("rm_add_a", 32'(add_a), 0);
    chk("rm_valid", 32'(rsp_valid), 0);
    chk("rm_sum", 32'(rsp_sum), 0);
    chk("rm_busy", 32'(busy), 0);
    step();
    chk("rm_no_rsp", 32'(rsp_valid), 0);
    chk("rm_cnt", 32'(op_count), 0);
    // ptr=0 picks requester 0 from 1001; a stale ptr=1 would pick 3.
    set_ops(0, 8'd3, 8'd4);
    req = 4'b1001;
    step();
    chk("rm_ptr0", 32'(gnt), 32'b0001);

    // Withdraw: requester 3 pulses while busy and must never be granted.
    req = 4'b1000;
    step();
    req = '0;
    chk("wd_sum", 32'(rsp_sum), 7);
    step();
    chk("wd_cnt", 32'(op_count), 1);
    step();
    chk("wd_no_gnt", 32'(gnt), 0);
    set_ops(1, 8'd20, 8'd22);
    req = 4'b0010;
    step();
    req = '0;
    chk("wd_gnt1", 32'(gnt), 32'b0010);
    step();
    chk("wd_id", 32'(rsp_id), 1);
    chk("wd_sum1", 32'(rsp_sum), 42);
    step();
    chk("wd_cnt2", 32'(op_count), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
